// File: rtl/ahbl_sram_bridge_pkg.sv
// Shared definitions for the AHB-Lite to SRAM bridge: AHB transfer and size
// encodings, and the byte-lane mask derived from a transfer's size and low
// address bits.
package ahbl_sram_bridge_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  // Byte lanes touched by a transfer on a 32-bit bus. Sizes above a word
  // cannot fit the bus, so they are treated as full-word accesses.
  function automatic logic [3:0] byte_mask(input logic [2:0] size,
                                           input logic [1:0] addr_lo);
    case (size)
      HSIZE_BYTE: byte_mask = 4'b0001 << addr_lo;
      HSIZE_HALF: byte_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:    byte_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahbl_sram_wbuf.sv
// One-entry posted write buffer for the AHB-Lite SRAM bridge.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   load, load_*          capture a completed write data phase
//   drain                 the SRAM port is writing the buffer this cycle
//   wb_valid/addr/mask/data  buffer contents (drive the SRAM write port)
//   fwd_en, fwd_addr      read data phase qualifier and its word address
//   mem_rdata             data returned by the SRAM
//   merged_rdata          SRAM data with buffered bytes forwarded over it
module ahbl_sram_wbuf
  import ahbl_sram_bridge_pkg::*;
#(
  parameter int W_DATA = 32,
  parameter int W_SRAM = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [W_SRAM-1:0]     load_addr,
  input  logic [W_DATA/8-1:0]   load_mask,
  input  logic [W_DATA-1:0]     load_data,
  input  logic                  drain,
  output logic                  wb_valid,
  output logic [W_SRAM-1:0]     wb_addr,
  output logic [W_DATA/8-1:0]   wb_mask,
  output logic [W_DATA-1:0]     wb_data,
  input  logic                  fwd_en,
  input  logic [W_SRAM-1:0]     fwd_addr,
  input  logic [W_DATA-1:0]     mem_rdata,
  output logic [W_DATA-1:0]     merged_rdata
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
    end else if (load) begin
      // A load in the same cycle as a drain wins: the old entry is being
      // written to SRAM right now, the new one takes its place.
      wb_valid <= 1'b1;
    end else if (drain) begin
      wb_valid <= 1'b0;
    end
  end

  // NOTE: the payload needs no reset; it is only observed while wb_valid is
  // set, which is reset. Leaving it unreset keeps these plain enable flops.
  always_ff @(posedge clk) begin
    if (load) begin
      wb_addr <= load_addr;
      wb_mask <= load_mask;
      wb_data <= load_data;
    end
  end

  // The buffer always holds the newest write older than a read in its data
  // phase, so a byte-wise overlay gives coherent read data.
  logic fwd_hit;
  assign fwd_hit = fwd_en && wb_valid && (wb_addr == fwd_addr);

  // NOTE: combinational outputs get a default first so no path infers a latch.
  always_comb begin
    merged_rdata = mem_rdata;
    for (int i = 0; i < W_DATA / 8; i++) begin
      if (fwd_hit && wb_mask[i]) merged_rdata[8*i +: 8] = wb_data[8*i +: 8];
    end
  end

endmodule

// File: rtl/ahbl_sram_bridge.sv
// AHB-Lite subordinate driving a single-port synchronous SRAM (active-low
// select, write and byte enables, 1-cycle read latency). Reads are zero-wait;
// writes are posted through a one-entry buffer because AHB write data arrives
// a cycle after the address.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   ahbls_*                    AHB-Lite subordinate interface
//   sram_cs_n/we_n/be_n        SRAM controls, active low
//   sram_addr, sram_wdata      SRAM word address and write data
//   sram_rdata                 SRAM read data, valid the cycle after a read
module ahbl_sram_bridge
  import ahbl_sram_bridge_pkg::*;
#(
  parameter  int W_DATA = 32,
  parameter  int W_ADDR = 32,
  parameter  int DEPTH  = 512,
  localparam int W_SRAM = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                rst_n,
  input  logic                ahbls_hready,
  output logic                ahbls_hready_resp,
  output logic                ahbls_hresp,
  input  logic                ahbls_hsel,
  input  logic [W_ADDR-1:0]   ahbls_haddr,
  input  logic                ahbls_hwrite,
  input  logic [1:0]          ahbls_htrans,
  input  logic [2:0]          ahbls_hsize,
  input  logic [W_DATA-1:0]   ahbls_hwdata,
  output logic [W_DATA-1:0]   ahbls_hrdata,
  output logic                sram_cs_n,
  output logic                sram_we_n,
  output logic [W_DATA/8-1:0] sram_be_n,
  output logic [W_SRAM-1:0]   sram_addr,
  output logic [W_DATA-1:0]   sram_wdata,
  input  logic [W_DATA-1:0]   sram_rdata
);

  if (W_DATA != 32) begin : g_width_check
    $fatal(1, "ahbl_sram_bridge: W_DATA must be 32");
  end

  // Address phase decode.
  logic                aph_valid;
  logic                aph_read;
  logic                aph_write;
  logic [W_SRAM-1:0]   aph_addr;
  logic [W_DATA/8-1:0] aph_mask;

  assign aph_valid = ahbls_hsel && ahbls_htrans[1];
  assign aph_read  = aph_valid && !ahbls_hwrite;
  assign aph_write = aph_valid && ahbls_hwrite;
  assign aph_addr  = ahbls_haddr[2 +: W_SRAM];  // wraps modulo DEPTH
  assign aph_mask  = byte_mask(ahbls_hsize, ahbls_haddr[1:0]);

  // Upper address bits and the SEQ/NONSEQ distinction do not matter here.
  logic unused_bits;
  assign unused_bits = ^{ahbls_haddr[W_ADDR-1:W_SRAM+2], ahbls_htrans[0]};

  // Data phase registers, advanced only when the bus moves on.
  logic                dph_read;
  logic                dph_write;
  logic [W_SRAM-1:0]   dph_addr;
  logic [W_DATA/8-1:0] dph_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dph_read  <= 1'b0;
      dph_write <= 1'b0;
      dph_addr  <= '0;
      dph_mask  <= '0;
    end else if (ahbls_hready) begin
      dph_read  <= aph_read;
      dph_write <= aph_write;
      dph_addr  <= aph_addr;
      dph_mask  <= aph_mask;
    end
  end

  // Buffer interface.
  logic                wb_valid;
  logic [W_SRAM-1:0]   wb_addr;
  logic [W_DATA/8-1:0] wb_mask;
  logic [W_DATA-1:0]   wb_data;
  logic                stall;
  logic                rd_issue;
  logic                drain;
  logic                load;

  // Stall only when the buffer is full, a read owns the SRAM port and new
  // write data must be accepted. The stalled read is not accepted by the bus,
  // so its slot goes to the drain instead; the read is reissued next cycle.
  // None of this depends on the global hready, so there is no loop through
  // the interconnect.
  assign stall    = dph_write && wb_valid && aph_read;
  assign rd_issue = aph_read && !stall;
  assign drain    = wb_valid && !rd_issue;
  assign load     = dph_write && ahbls_hready_resp;

  assign ahbls_hready_resp = !stall;
  assign ahbls_hresp       = 1'b0;

  ahbl_sram_wbuf #(
    .W_DATA (W_DATA),
    .W_SRAM (W_SRAM)
  ) u_wbuf (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (load),
    .load_addr    (dph_addr),
    .load_mask    (dph_mask),
    .load_data    (ahbls_hwdata),
    .drain        (drain),
    .wb_valid     (wb_valid),
    .wb_addr      (wb_addr),
    .wb_mask      (wb_mask),
    .wb_data      (wb_data),
    .fwd_en       (dph_read),
    .fwd_addr     (dph_addr),
    .mem_rdata    (sram_rdata),
    .merged_rdata (ahbls_hrdata)
  );

  // SRAM port: read first, then drain, else idle with buffer values parked.
  always_comb begin
    sram_cs_n  = 1'b1;
    sram_we_n  = 1'b1;
    sram_be_n  = ~wb_mask;
    sram_addr  = wb_addr;
    sram_wdata = wb_data;
    if (rd_issue) begin
      sram_cs_n = 1'b0;
      sram_be_n = '0;
      sram_addr = aph_addr;
    end else if (wb_valid) begin
      sram_cs_n = 1'b0;
      sram_we_n = 1'b0;
    end
  end

endmodule

// File: tb/tb_ahbl_sram_bridge.sv
// Self-checking bench for ahbl_sram_bridge. A byte-addressed reference memory
// is updated from each completed AHB write data phase and every read data
// phase is compared against it; literal expectations pin specific results.
module tb_ahbl_sram_bridge;

  localparam int DEPTH = 512;
  localparam int NBYTE = 4 * DEPTH;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ahbls_hready;
  logic        ahbls_hready_resp;
  logic        ahbls_hresp;
  logic        ahbls_hsel = 1'b0;
  logic [31:0] ahbls_haddr = '0;
  logic        ahbls_hwrite = 1'b0;
  logic [1:0]  ahbls_htrans = 2'b00;
  logic [2:0]  ahbls_hsize = 3'd2;
  logic [31:0] ahbls_hwdata = '0;
  logic [31:0] ahbls_hrdata;
  logic        sram_cs_n;
  logic        sram_we_n;
  logic [3:0]  sram_be_n;
  logic [8:0]  sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata = '0;

  always #5 clk = ~clk;

  // Single subordinate on the bus: global HREADY is our own HREADYOUT.
  assign ahbls_hready = ahbls_hready_resp;

  ahbl_sram_bridge #(.W_DATA(32), .W_ADDR(32), .DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ahbls_hready      (ahbls_hready),
    .ahbls_hready_resp (ahbls_hready_resp),
    .ahbls_hresp       (ahbls_hresp),
    .ahbls_hsel        (ahbls_hsel),
    .ahbls_haddr       (ahbls_haddr),
    .ahbls_hwrite      (ahbls_hwrite),
    .ahbls_htrans      (ahbls_htrans),
    .ahbls_hsize       (ahbls_hsize),
    .ahbls_hwdata      (ahbls_hwdata),
    .ahbls_hrdata      (ahbls_hrdata),
    .sram_cs_n         (sram_cs_n),
    .sram_we_n         (sram_we_n),
    .sram_be_n         (sram_be_n),
    .sram_addr         (sram_addr),
    .sram_wdata        (sram_wdata),
    .sram_rdata        (sram_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  // SRAM macro model.
  logic [31:0] sram [0:DEPTH-1];
  initial for (int i = 0; i < DEPTH; i++) sram[i] <= init_word(i);

  always @(posedge clk) begin
    if (!sram_cs_n) begin
      if (!sram_we_n) begin
        for (int b = 0; b < 4; b++)
          if (!sram_be_n[b]) sram[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= sram[sram_addr];
      end
    end
  end

  // Reference memory, byte addressed, wrapping modulo the SRAM size.
  logic [7:0] ref_mem [0:NBYTE-1];
  initial for (int i = 0; i < DEPTH; i++)
    for (int b = 0; b < 4; b++) ref_mem[4*i+b] = init_word(i) >> (8*b);

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int base;
    base = int'(a % NBYTE) & ~3;
    return {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [2:0] size,
                           input logic [31:0] data);
    int nb, base;
    nb   = (size == 3'd0) ? 1 : (size == 3'd1) ? 2 : 4;
    base = int'(a % NBYTE) & ~(nb - 1);
    for (int j = 0; j < nb; j++)
      ref_mem[base+j] = data[8*((base+j)%4) +: 8];
  endtask

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Observation: SRAM write log, read cycles, stalls, and the per-cycle
  // comparison of read data against the reference memory.
  typedef struct {
    int          cyc;
    logic [8:0]  addr;
    logic [3:0]  be_n;
    logic [31:0] data;
  } wr_t;

  wr_t         wlog[$];
  int          cyc = 0;
  int          last_rd_cyc = -1;
  int          stall_cnt = 0;
  logic [31:0] last_hrdata = '0;
  logic        m_rd = 1'b0;
  logic        m_wr = 1'b0;
  logic [31:0] m_addr = '0;
  logic [2:0]  m_size = '0;

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      m_rd = 1'b0;
      m_wr = 1'b0;
    end else begin
      check("hresp", {31'd0, ahbls_hresp}, 32'd0);
      if (!sram_cs_n && !sram_we_n)
        wlog.push_back('{cyc: cyc, addr: sram_addr, be_n: sram_be_n, data: sram_wdata});
      else if (!sram_cs_n)
        last_rd_cyc = cyc;
      if (!ahbls_hready_resp) begin
        stall_cnt++;
      end else begin
        if (m_rd) begin
          check("hrdata", ahbls_hrdata, ref_word(m_addr));
          last_hrdata = ahbls_hrdata;
        end
        if (m_wr) ref_write(m_addr, m_size, ahbls_hwdata);
        m_rd   = ahbls_hsel && ahbls_htrans[1] && !ahbls_hwrite;
        m_wr   = ahbls_hsel && ahbls_htrans[1] && ahbls_hwrite;
        m_addr = ahbls_haddr;
        m_size = ahbls_hsize;
      end
    end
  end

  // Stimulus: a queue of transfers issued back to back on the bus.
  typedef struct {
    bit          valid;
    bit          write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] data;
  } xfer_t;

  xfer_t xq[$];

  task automatic wr(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
    xq.push_back('{valid: 1'b1, write: 1'b1, addr: a, size: s, data: d});
  endtask

  task automatic rd(input logic [31:0] a);
    xq.push_back('{valid: 1'b1, write: 1'b0, addr: a, size: 3'd2, data: 32'd0});
  endtask

  task automatic nop();
    xq.push_back('{valid: 1'b0, write: 1'b0, addr: 32'd0, size: 3'd2, data: 32'd0});
  endtask

  // Wait until the current cycle completes with HREADY high, bounded.
  task automatic wait_accept();
    int budget;
    budget = 0;
    forever begin
      @(negedge clk);
      if (ahbls_hready_resp) break;
      budget++;
      if (budget > 8) begin
        checks++;
        errors++;
        $display("FAIL hready_timeout: hready_resp stuck at 0 for %0d cycles, required release", budget);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    ahbls_hsel   = 1'b0;
    ahbls_htrans = 2'b00;
    ahbls_hwrite = 1'b0;
    ahbls_hwdata = '0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_xq();
    bit          pend_w;
    logic [31:0] pend_d;
    int          n;
    pend_w = 1'b0;
    pend_d = '0;
    n = xq.size();
    for (int i = 0; i <= n; i++) begin
      if (i < n && xq[i].valid) begin
        ahbls_hsel   = 1'b1;
        ahbls_htrans = 2'b10;
        ahbls_haddr  = xq[i].addr;
        ahbls_hwrite = xq[i].write;
        ahbls_hsize  = xq[i].size;
      end else begin
        ahbls_hsel   = 1'b0;
        ahbls_htrans = 2'b00;
        ahbls_hwrite = 1'b0;
      end
      ahbls_hwdata = pend_w ? pend_d : 32'h0;
      wait_accept();
      pend_w = (i < n) && xq[i].valid && xq[i].write;
      pend_d = (i < n) ? xq[i].data : 32'h0;
    end
    xq.delete();
    idle(3);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  int w0, s0, diffs;

  initial begin
    // Reset state.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hready_resp", {31'd0, ahbls_hready_resp}, 32'd1);
    check("rst_cs_n", {31'd0, sram_cs_n}, 32'd1);
    check("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    rst_n = 1'b1;
    idle(2);

    // 1: posted word write drains the following cycle, then reads back.
    w0 = wlog.size();
    s0 = stall_cnt;
    wr(32'h10, 3'd2, 32'hDEAD_BEEF);
    nop();
    run_xq();
    check("t1_wr_count", wlog.size() - w0, 1);
    check("t1_wr_addr", {23'd0, wlog[w0].addr}, 32'd4);
    check("t1_wr_be_n", {28'd0, wlog[w0].be_n}, 32'h0);
    check("t1_wr_data", wlog[w0].data, 32'hDEAD_BEEF);
    rd(32'h10);
    run_xq();
    check("t1_rd", last_hrdata, 32'hDEAD_BEEF);
    check("t1_stalls", stall_cnt - s0, 0);

    // 2: byte write then immediate read of the same word: forwarded byte.
    w0 = wlog.size();
    wr(32'h21, 3'd0, 32'h0000_AB00);
    rd(32'h20);
    run_xq();
    check("t2_rd_fwd", last_hrdata, 32'hC0DE_AB08);
    check("t2_wr_be_n", {28'd0, wlog[w0].be_n}, 32'b1101);
    check("t2_wr_after_rd", {31'd0, wlog[w0].cyc > last_rd_cyc}, 32'd1);

    // 3: two writes then a read: exactly one wait state, writes in order.
    w0 = wlog.size();
    s0 = stall_cnt;
    wr(32'h0, 3'd2, 32'hA5A5_0001);
    wr(32'h4, 3'd2, 32'hB6B6_0002);
    rd(32'h8);
    run_xq();
    check("t3_stalls", stall_cnt - s0, 1);
    check("t3_wr_count", wlog.size() - w0, 2);
    check("t3_first_addr", {23'd0, wlog[w0].addr}, 32'd0);
    check("t3_first_data", wlog[w0].data, 32'hA5A5_0001);
    check("t3_second_addr", {23'd0, wlog[w0+1].addr}, 32'd1);
    check("t3_second_data", wlog[w0+1].data, 32'hB6B6_0002);
    check("t3_rd", last_hrdata, 32'hC0DE_0002);

    // 4: posted write followed by 20 reads: buffer holds, reads forward.
    w0 = wlog.size();
    wr(32'h40, 3'd2, 32'h4444_CAFE);
    for (int i = 0; i < 20; i++) rd(32'h40);
    run_xq();
    check("t4_rd_fwd", last_hrdata, 32'h4444_CAFE);
    check("t4_wr_count", wlog.size() - w0, 1);
    check("t4_wr_after_reads", {31'd0, wlog[w0].cyc > last_rd_cyc}, 32'd1);

    // 5: halfword merge, plus an address beyond DEPTH that wraps.
    wr(32'h32, 3'd1, 32'h1234_0000);
    wr(32'h30, 3'd1, 32'h0000_5678);
    wr(32'h814, 3'd2, 32'h7777_0005);
    rd(32'h30);
    run_xq();
    check("t5_rd_half", last_hrdata, 32'h1234_5678);
    check("t5_sram_word", sram[12], 32'h1234_5678);
    rd(32'h14);
    run_xq();
    check("t5_rd_wrap", last_hrdata, 32'h7777_0005);

    // Whole-array comparison of the SRAM against the reference memory.
    diffs = 0;
    for (int i = 0; i < DEPTH; i++)
      if (sram[i] !== ref_word(32'(4 * i))) diffs++;
    check("mem_sweep_diffs", diffs, 0);

    // 6: reset while a write sits in the buffer drops it.
    w0 = wlog.size();
    ahbls_hsel   = 1'b1;
    ahbls_htrans = 2'b10;
    ahbls_haddr  = 32'h60;
    ahbls_hwrite = 1'b1;
    ahbls_hsize  = 3'd2;
    wait_accept();
    ahbls_hsel   = 1'b0;
    ahbls_htrans = 2'b00;
    ahbls_hwrite = 1'b0;
    ahbls_hwdata = 32'h6666_6666;
    wait_accept();
    check("t6_drain_pending", {30'd0, sram_cs_n, sram_we_n}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("t6_rst_hready_resp", {31'd0, ahbls_hready_resp}, 32'd1);
    check("t6_rst_cs_n", {31'd0, sram_cs_n}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(4);
    check("t6_no_write", wlog.size() - w0, 0);
    check("t6_sram_word", sram[24], 32'hC0DE_0018);
    for (int b = 0; b < 4; b++) ref_mem[96+b] = init_word(24) >> (8*b);
    rd(32'h60);
    run_xq();
    check("t6_rd_after_rst", last_hrdata, 32'hC0DE_0018);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
